// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for the RISC-V core.
// Sequences fetch/decode/execute/memory/write-back for the supported
// subset. It waits on mem_ready in memory states and traps on
// unsupported encodings.
module mc_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        EQ,
   input  logic        mem_ready,
   output logic [2:0]  ALUctrl,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ResultSrc,
   output logic        AdrSrc,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        retire,
   output logic        illegal
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
      S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_TRAP
   } state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STOR = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;

   state_t      state_q;
   logic        bne_q;      // branch sense captured in DECODE

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7]};

   // Only add/sub/and/or/slt are accepted among R-type encodings.
   function automatic logic r_legal(input logic [6:0] f7, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (f7 == 7'b0000000)
         ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
      else if (f7 == 7'b0100000)
         ok = (f3 == 3'b000);
      return ok;
   endfunction

   // ALU operation for a legal R-type instruction.
   function automatic logic [2:0] r_alu(input logic [6:0] f7, input logic [2:0] f3);
      logic [2:0] op;
      op = 3'b000;
      case (f3)
         3'b000:  op = (f7 == 7'b0100000) ? 3'b001 : 3'b000;
         3'b111:  op = 3'b010;
         3'b110:  op = 3'b011;
         3'b010:  op = 3'b101;
         default: op = 3'b000;
      endcase
      return op;
   endfunction

   // State sequencing; reset restarts at FETCH and is the only exit from TRAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         bne_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH:     if (mem_ready) state_q <= S_DECODE;
            S_DECODE: begin
               bne_q <= funct3[0];
               if (opcode == OP_R && r_legal(funct7, funct3))
                  state_q <= S_EXEC_R;
               else if (opcode == OP_IMM && funct3 == 3'b000)
                  state_q <= S_EXEC_I;
               else if ((opcode == OP_LOAD || opcode == OP_STOR) && funct3 == 3'b010)
                  state_q <= S_MEM_ADDR;
               else if (opcode == OP_BR && (funct3 == 3'b000 || funct3 == 3'b001))
                  state_q <= S_BRANCH;
               else
                  state_q <= S_TRAP;
            end
            S_EXEC_R:    state_q <= S_ALU_WB;
            S_EXEC_I:    state_q <= S_ALU_WB;
            S_ALU_WB:    state_q <= S_FETCH;
            S_MEM_ADDR:  state_q <= (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_q <= S_MEM_WB;
            S_MEM_WB:    state_q <= S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_q <= S_FETCH;
            S_BRANCH:    state_q <= S_FETCH;
            S_TRAP:      state_q <= S_TRAP;
            default:     state_q <= S_FETCH;
         endcase
      end
   end

   // Moore output decode; write enables are forced low while reset is held.
   always_comb begin
      ALUctrl   = 3'b000;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = 2'b00;
      ResultSrc = 2'b00;
      AdrSrc    = 1'b0;
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = 2'b10;
         end
         S_EXEC_R: begin
            ALUSrcA = 2'b10;
            ALUctrl = r_alu(funct7, funct3);
         end
         S_EXEC_I: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_ALU_WB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (opcode == OP_LOAD) ? 2'b00 : 2'b01;
         end
         S_MEM_READ: AdrSrc = 1'b1;
         S_MEM_WB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            retire    = 1'b1;
         end
         S_MEM_WRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            retire   = mem_ready;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b10;
            ALUctrl = 3'b001;
            PCWrite = bne_q ? ~EQ : EQ;
            retire  = 1'b1;
         end
         S_TRAP:  illegal = 1'b1;
         default: illegal = 1'b0;
      endcase
      if (rst) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         retire   = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: each step pushes its expected output
// vector to a scoreboard queue, which is popped and compared mid-cycle.
module tb_mc_control;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        EQ = 1'b0;
   logic        mem_ready = 1'b0;
   logic [2:0]  ALUctrl;
   logic [1:0]  ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
   logic        AdrSrc, PCWrite, IRWrite, RegWrite, MemWrite, retire, illegal;

   mc_control dut (
      .clk(clk), .rst(rst), .instr(instr), .EQ(EQ), .mem_ready(mem_ready),
      .ALUctrl(ALUctrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .PCWrite(PCWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .retire(retire), .illegal(illegal)
   );

   always #5 clk = ~clk;

   logic [17:0] obs;
   assign obs = {ALUctrl, ALUSrcA, ALUSrcB, ImmSrc, ResultSrc, AdrSrc,
                 PCWrite, IRWrite, RegWrite, MemWrite, retire, illegal};

   typedef struct {
      string       tag;
      logic [17:0] exp;
   } sb_t;
   sb_t sbq[$];

   int checks = 0;
   int failures = 0;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_ADDI = 32'h00108093;
   localparam logic [31:0] I_LW   = 32'h0040A183;
   localparam logic [31:0] I_SW   = 32'h0030A223;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_BNE  = 32'h00209463;
   localparam logic [31:0] I_JAL  = 32'h0000006F;

   function automatic logic [17:0] ev(input logic [2:0] alu, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] imm,
                                      input logic [1:0] rs, input logic adr,
                                      input logic pcw, input logic irw, input logic rw,
                                      input logic mw, input logic ret, input logic ill);
      return {alu, sa, sb, imm, rs, adr, pcw, irw, rw, mw, ret, ill};
   endfunction

   function automatic logic [17:0] e_rst();
      return ev(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_fetch(input logic mr);
      return ev(3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, mr, mr, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_decode();
      return ev(3'b000, 2'b01, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_exec_r(input logic [2:0] alu);
      return ev(alu, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_exec_i();
      return ev(3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_alu_wb();
      return ev(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
   endfunction
   function automatic logic [17:0] e_mem_addr(input logic [1:0] imm);
      return ev(3'b000, 2'b10, 2'b01, imm, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_mem_read();
      return ev(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction
   function automatic logic [17:0] e_mem_wb();
      return ev(3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
   endfunction
   function automatic logic [17:0] e_mem_write(input logic mr);
      return ev(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mr, 1'b0);
   endfunction
   function automatic logic [17:0] e_branch(input logic pcw);
      return ev(3'b001, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, pcw, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endfunction
   function automatic logic [17:0] e_trap();
      return ev(3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction

   task automatic push(input string tag, input logic [17:0] exp);
      sb_t item;
      item.tag = tag;
      item.exp = exp;
      sbq.push_back(item);
   endtask

   task automatic check_one();
      sb_t item;
      checks++;
      if (sbq.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_underflow: observed=%h required=entry", obs);
      end else begin
         item = sbq.pop_front();
         assert (obs === item.exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", item.tag, obs, item.exp);
         end
      end
   endtask

   // One clock cycle: drive, push expectation, compare at negedge.
   task automatic cyc(input logic mr, input logic eq, input logic [31:0] ins,
                      input string tag, input logic [17:0] exp);
      mem_ready = mr;
      EQ        = eq;
      instr     = ins;
      push(tag, exp);
      @(negedge clk);
      check_one();
      @(posedge clk);
      #1;
   endtask

   task automatic run_r(input logic [31:0] ins, input logic [2:0] alu, input string tag);
      cyc(1'b1, 1'b0, ins, {tag, "_fetch"}, e_fetch(1'b1));
      cyc(1'b1, 1'b0, ins, {tag, "_decode"}, e_decode());
      cyc(1'b1, 1'b0, ins, {tag, "_exec"}, e_exec_r(alu));
      cyc(1'b1, 1'b0, ins, {tag, "_wb"}, e_alu_wb());
   endtask

   task automatic run_br(input logic [31:0] ins, input logic eq, input logic pcw, input string tag);
      cyc(1'b1, eq, ins, {tag, "_fetch"}, e_fetch(1'b1));
      cyc(1'b1, eq, ins, {tag, "_decode"}, e_decode());
      cyc(1'b1, eq, ins, {tag, "_branch"}, e_branch(pcw));
   endtask

   logic [31:0] r_ins[4] = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3};
   logic [2:0]  r_alu[4] = '{3'b001, 3'b010, 3'b011, 3'b101};

   initial begin
      @(posedge clk);
      #1;
      // reset held: enables low even with mem_ready high
      cyc(1'b1, 1'b0, I_ADD, "reset_0", e_rst());
      cyc(1'b1, 1'b1, I_ADD, "reset_1", e_rst());
      rst = 1'b0;

      // add: 4 cycles, first fetch immediately after reset release
      run_r(I_ADD, 3'b000, "add");
      for (int i = 0; i < 4; i++) run_r(r_ins[i], r_alu[i], $sformatf("rop%0d", i));

      // addi with one fetch wait cycle
      cyc(1'b0, 1'b0, I_ADDI, "addi_fetch_wait", e_fetch(1'b0));
      cyc(1'b1, 1'b0, I_ADDI, "addi_fetch", e_fetch(1'b1));
      cyc(1'b1, 1'b0, I_ADDI, "addi_decode", e_decode());
      cyc(1'b1, 1'b0, I_ADDI, "addi_exec", e_exec_i());
      cyc(1'b1, 1'b0, I_ADDI, "addi_wb", e_alu_wb());

      // lw with three wait cycles in MEM_READ: 8 cycles total
      cyc(1'b1, 1'b0, I_LW, "lw_fetch", e_fetch(1'b1));
      cyc(1'b1, 1'b0, I_LW, "lw_decode", e_decode());
      cyc(1'b1, 1'b0, I_LW, "lw_addr", e_mem_addr(2'b00));
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, I_LW, "lw_read_wait", e_mem_read());
      cyc(1'b1, 1'b0, I_LW, "lw_read", e_mem_read());
      cyc(1'b1, 1'b0, I_LW, "lw_wb", e_mem_wb());

      // sw with one wait cycle, retire only on the completing cycle
      cyc(1'b1, 1'b0, I_SW, "sw_fetch", e_fetch(1'b1));
      cyc(1'b1, 1'b0, I_SW, "sw_decode", e_decode());
      cyc(1'b1, 1'b0, I_SW, "sw_addr", e_mem_addr(2'b01));
      cyc(1'b0, 1'b0, I_SW, "sw_write_wait", e_mem_write(1'b0));
      cyc(1'b1, 1'b0, I_SW, "sw_write", e_mem_write(1'b1));

      // branches
      run_br(I_BEQ, 1'b1, 1'b1, "beq_taken");
      run_br(I_BEQ, 1'b0, 1'b0, "beq_not");
      run_br(I_BNE, 1'b0, 1'b1, "bne_taken");
      run_br(I_BNE, 1'b1, 1'b0, "bne_not");

      // sw aborted by reset during MEM_WRITE
      cyc(1'b1, 1'b0, I_SW, "swr_fetch", e_fetch(1'b1));
      cyc(1'b1, 1'b0, I_SW, "swr_decode", e_decode());
      cyc(1'b1, 1'b0, I_SW, "swr_addr", e_mem_addr(2'b01));
      mem_ready = 1'b0;
      push("swr_write_wait", e_mem_write(1'b0));
      @(negedge clk);
      check_one();
      #2;
      rst = 1'b1;
      mem_ready = 1'b1;
      push("swr_async_drop", e_rst());
      #1;
      check_one();
      @(posedge clk);
      #1;
      cyc(1'b1, 1'b0, I_SW, "swr_reset_hold", e_rst());
      rst = 1'b0;
      cyc(1'b1, 1'b0, I_ADD, "swr_refetch", e_fetch(1'b1));
      cyc(1'b1, 1'b0, I_ADD, "swr_decode2", e_decode());
      cyc(1'b1, 1'b0, I_ADD, "swr_exec2", e_exec_r(3'b000));
      cyc(1'b1, 1'b0, I_ADD, "swr_wb2", e_alu_wb());

      // unsupported jal traps; sticky for 20 cycles regardless of inputs
      cyc(1'b1, 1'b0, I_JAL, "jal_fetch", e_fetch(1'b1));
      cyc(1'b1, 1'b0, I_JAL, "jal_decode", e_decode());
      for (int i = 0; i < 20; i++)
         cyc(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, "trap_hold", e_trap());
      rst = 1'b1;
      cyc(1'b1, 1'b0, I_ADD, "trap_reset", e_rst());
      rst = 1'b0;
      run_r(I_ADD, 3'b000, "post_trap_add");

      checks++;
      assert (sbq.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_drain: observed=%0d expected=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM for the RISC-V core. It drives the `ALUctrl` code and the datapath enables and multiplexer selects, and consumes the ALU `EQ` flag to resolve branches. It sequences fetch, decode, execute, memory and write-back for the supported instruction subset. It handles a variable-latency memory through a `mem_ready` handshake and traps on unsupported encodings.

## Interface
Parameters: none.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction register contents, valid from DECODE onward.
- `EQ` in 1: ALU flag, high when `ALUout == 0`.
- `mem_ready` in 1: memory completes the current access this cycle.
- `ALUctrl` out 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB` out 2: 00 RD2, 01 Imm, 10 constant 4.
- `ImmSrc` out 2: 00 I-type, 01 S-type, 10 B-type.
- `ResultSrc` out 2: 00 ALUOut register, 01 Data register, 10 ALU result direct.
- `AdrSrc` out 1: memory address select, 0 PC, 1 Result.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1 each: datapath write enables.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `illegal` out 1: sticky trap flag.

## Operation
- Moore FSM. Outputs are decoded from the state, except `PCWrite` and `IRWrite`, which also depend on `mem_ready` and `EQ` as listed below. Unlisted outputs are 0 in every state.
- FETCH:
  - `AdrSrc=0`, `ALUSrcA=00`, `ALUSrcB=10`, `ALUctrl=000`, `ResultSrc=10`.
  - `IRWrite = PCWrite = mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: `ALUSrcA=01`, `ALUSrcB=01`, `ImmSrc=10`, `ALUctrl=000` (branch target precompute). Next state by `opcode`/`funct3`/`funct7`:
  - 0110011 R-type, only add, sub, and, or, slt encodings -> EXEC_R.
  - 0010011 with `funct3=000` (addi) -> EXEC_I.
  - 0000011 with `funct3=010` (lw) or 0100011 with `funct3=010` (sw) -> MEM_ADDR.
  - 1100011 with `funct3=000` (beq) or `001` (bne) -> BRANCH.
  - Anything else -> TRAP.
- EXEC_R: `ALUSrcA=10`, `ALUSrcB=00`; next ALU_WB. `ALUctrl` from `funct7`/`funct3`:
  - 0000000/000 -> 000 (add); 0100000/000 -> 001 (sub).
  - 0000000/111 -> 010 (and); 0000000/110 -> 011 (or); 0000000/010 -> 101 (slt).
- EXEC_I: `ALUSrcA=10`, `ALUSrcB=01`, `ImmSrc=00`, `ALUctrl=000`; next ALU_WB.
- ALU_WB: `ResultSrc=00`, `RegWrite=1`, `retire=1`; next FETCH.
- MEM_ADDR: `ALUSrcA=10`, `ALUSrcB=01`, `ALUctrl=000`, `ImmSrc` 00 for lw, 01 for sw; next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: `AdrSrc=1`, `ResultSrc=00`; holds until `mem_ready`, then MEM_WB.
- MEM_WB: `ResultSrc=01`, `RegWrite=1`, `retire=1`; next FETCH.
- MEM_WRITE: `AdrSrc=1`, `ResultSrc=00`, `MemWrite=1` held until `mem_ready`; `retire=mem_ready`; then FETCH.
- BRANCH: `ALUSrcA=10`, `ALUSrcB=00`, `ALUctrl=001`, `ResultSrc=00`; `PCWrite = EQ` (beq) or `!EQ` (bne); `retire=1`; next FETCH.
- TRAP: `illegal=1`, all enables 0, no exit; only `rst` leaves it.

## Timing
- Reset: state forced to FETCH asynchronously. While `rst` is high, `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `retire` and `illegal` are 0 regardless of `mem_ready`.
- First fetch may complete in the first cycle after `rst` deasserts.
- Latency in cycles, each memory state adding one cycle per wait:
  - R-type/addi: 4.
  - lw: 5.
  - sw: 4.
  - beq/bne: 3.
- Handshake: the memory request is implied by the state (FETCH, MEM_READ, MEM_WRITE). Any number of wait cycles is allowed; outputs are stable while waiting. `mem_ready` is ignored in all other states.
- `instr` is sampled only in DECODE, EXEC_R and MEM_ADDR; changes in other cycles have no effect.
- `rst` asserted mid-instruction aborts it: no `RegWrite` or `MemWrite` is issued after the reset edge, and the FSM restarts at FETCH.
- `illegal` rises in the cycle after DECODE and remains high until reset.

## Test plan
- Reset then `mem_ready=1`, `instr=0x002081B3` (add x3,x1,x2) -> FETCH, DECODE, EXEC_R with `ALUctrl=000`, ALU_WB with `RegWrite=1` and `retire=1`; 4 cycles total.
- `instr=0x402081B3` (sub), then `0x0020F1B3` (and), then `0x0020A1B3` (slt) -> `ALUctrl` in EXEC_R is 001, 010 and 101 respectively.
- lw `0x0040A183` with `mem_ready` low for 3 cycles in MEM_READ -> FSM holds in MEM_READ with `AdrSrc=1`, then MEM_WB with `ResultSrc=01`; 8 cycles total.
- beq `0x00208463`:
  - with `EQ=1` -> BRANCH has `ALUctrl=001` and `PCWrite=1`;
  - with `EQ=0` -> `PCWrite=0`;
  - bne `0x00209463` with `EQ=0` -> `PCWrite=1`.
- `instr=0x0000006F` (jal, unsupported) -> TRAP, `illegal=1` persists for 20 cycles and all enables stay 0; asserting `rst` clears it and the FSM returns to FETCH.
- sw `0x0030A223` with `rst` asserted during MEM_WRITE -> `MemWrite` drops asynchronously, state returns to FETCH, no `retire` pulse.
